// File: rtl/serial_adder.sv
// serial_adder: bit-serial two's-complement adder/subtractor with start/busy/done handshake
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic             done
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, carry_q, carry_d, ov_q, ov_d, s, c_nxt, last;
  always_comb begin
    s = a_q[0] ^ b_q[0] ^ c_q;
    c_nxt = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    last = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    res_d = res_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    carry_d = carry_q;
    ov_d = ov_q;
    if (start && state_q != RUN) begin
      state_d = RUN;
      a_d = a;
      b_d = sub ? ~b : b;
      c_d = sub | cin;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      c_d = c_nxt;
      res_d = (res_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        // c_q is the carry into the MSB while the last bit is processed
        sum_d = res_d;
        carry_d = c_nxt;
        ov_d = c_q ^ c_nxt;
        state_d = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      res_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      ov_q <= ov_d;
    end
  end
  assign sum = sum_q;
  assign carry = carry_q;
  assign overflow = ov_q;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised, bit-serial two's-complement adder/subtractor: the sequential successor to the 1-bit full adder driven from the Basys3 switches. Operands are captured on a start pulse and processed LSB-first, one bit per clock, through a single full-adder cell with a registered carry. The block reports sum, carry and signed overflow through a start/busy/done handshake. It sits between the switch/debounce front end and the display/LED logic on the board top level.

## Interface
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled on the rising edge, accepted only in IDLE or DONE
- sub  in  1  mode: 0 = a + b + cin, 1 = a - b (cin ignored)
- cin  in  1  carry-in for add mode
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sum  out  WIDTH  last completed result
- carry  out  1  carry out of the MSB; in sub mode 1 = no borrow
- overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse marking a completed result

## Operation
- One clock; reset is asynchronous and active-low.
- States:
  - IDLE: waiting for start.
  - RUN: processing bits.
  - DONE: one-cycle result-valid state.
- IDLE/DONE + start=1 -> RUN:
  - Latch a into the A shift register.
  - Latch (sub ? ~b : b) into the B shift register.
  - Set the carry flip-flop to (sub ? 1 : cin).
  - Clear the bit counter to 0.
- RUN, each cycle:
  - s = A[0] ^ B[0] ^ c.
  - c <= majority(A[0], B[0], c).
  - Shift s into the internal result register from the MSB end; shift A and B right.
  - Increment the counter.
- RUN, when the counter = WIDTH-1 (the last bit):
  - Load sum with the final result register value.
  - Load carry with the final carry.
  - Load overflow with (carry into MSB) XOR (final carry). Keep the carry-into-MSB value in a flip-flop for this.
  - Go to DONE.
- DONE -> IDLE unconditionally, unless start=1, which goes directly to RUN (back-to-back operation).
- start in RUN is ignored.
- a, b, cin and sub are sampled only at the accepting edge; changes during RUN have no effect.
- sum, carry and overflow change only at completion. They hold the last result through IDLE and through a following RUN.
- Arithmetic:
  - Add: sum = (a + b + cin) mod 2^WIDTH.
  - Sub: sum = (a - b) mod 2^WIDTH.
- WIDTH = 1 degenerates to the plain full adder: RUN lasts one cycle, and overflow = cin_to_msb ^ carry, with cin_to_msb = the initial carry.
- Counter width is $clog2(WIDTH), minimum 1 bit.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE; sum=0, carry=0, overflow=0, busy=0, done=0; all internal registers 0.
- Reset mid-RUN discards the operation. After release, no done appears until a new start.
- Edge k accepts start.
- busy=1 in the WIDTH cycles following edges k .. k+WIDTH-1.
- Edge k+WIDTH:
  - Processes the last bit.
  - Updates sum, carry and overflow.
  - Drops busy.
  - Raises done for exactly one cycle.
- Latency from the accepting edge to done = WIDTH+1 edges (done visible after edge k+WIDTH).
- Throughput: one result per WIDTH+1 cycles with start held high. A start in the DONE cycle is accepted at edge k+WIDTH+1.
- busy and done are never high together. All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: drive random inputs, then pulse rst_n low -> sum=0, carry=0, overflow=0, busy=0, done=0 asynchronously.
- WIDTH=1 sweep of a, b, cin over all 8 combos, add mode -> {carry, sum} matches the 3-switch full-adder truth table (e.g. 1,1,1 -> sum=1, carry=1); done after 2 edges each.
- WIDTH=8 add:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, carry=1, overflow=0; done exactly 8 edges after the accepting edge.
  - a=8'h7F, b=8'h01 -> sum=8'h80, carry=0, overflow=1.
- WIDTH=8 sub:
  - a=8'h05, b=8'h07 -> sum=8'hFE, carry=0, overflow=0.
  - a=8'h80, b=8'h01 -> sum=8'h7F, carry=1, overflow=1.
- Handshake:
  - Re-pulse start and change a/b/sub during RUN -> ignored; result matches the latched operands.
  - Hold start high -> back-to-back results, done every 9 cycles.
- rst_n low after 4 processed bits -> outputs 0 immediately; after release, busy=0 and done stays 0 until a new start.
